// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit
//   Multi-cycle unsigned multiply / multiply-accumulate unit for the EX stage.
//   Executes multu (op 0, func 25) and maddu (op 28, any func) by
//   shift-and-add into an internal HI/LO register pair, and drives a busy
//   signal that stalls the pipeline while an operation is in flight.
//
//   Optional feature: define MULT_EARLY_TERM_EN to leave RUN as soon as the
//   remaining multiplier bits are all zero (same result, shorter latency).
//   Without it every operation takes a fixed WIDTH+1 busy cycles.
//
// Handshake: start is a request sampled only while the unit is idle
//   (busy=0). A request seen while busy=1 is dropped; the upstream stage is
//   expected to hold its instruction under the stall. done is a single-cycle
//   pulse in the cycle after HI/LO were written; a new start in that same
//   cycle is accepted because the unit is already idle.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous active-high reset
//   start    in   operation request (decoder isMult)
//   op       in   [5:0] opcode
//   func     in   [5:0] function field
//   rs_val   in   [WIDTH-1:0] multiplicand
//   rt_val   in   [WIDTH-1:0] multiplier
//   busy     out  high while in RUN or COMMIT
//   done     out  one-cycle pulse after HI/LO update
//   hi       out  [WIDTH-1:0] HI register
//   lo       out  [WIDTH-1:0] LO register
//   state_o  out  [1:0] current FSM state (debug observation)
// ---------------------------------------------------------------------------
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_o
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [CW-1:0]      count_q, count_d;
    logic               maddu_q, maddu_d;   // 1: accumulate, 0: overwrite
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic is_multu;
    logic is_maddu;

    assign is_multu = (op == 6'd0) && (func == 6'd25);
    assign is_maddu = (op == 6'd28);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;
        maddu_d   = maddu_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (is_multu || is_maddu)) begin
                    maddu_d   = is_maddu;
                    mcand_d   = {{WIDTH{1'b0}}, rs_val};
                    mplier_d  = rt_val;
                    product_d = '0;
                    count_d   = '0;
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                if (mplier_q[0]) begin
                    product_d = product_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_d == CW'(WIDTH)) begin
                    state_d = S_COMMIT;
                end
`ifdef MULT_EARLY_TERM_EN
                // No set bits left in the multiplier: nothing more to add.
                if (mplier_d == '0) begin
                    state_d = S_COMMIT;
                end
`endif
            end

            S_COMMIT: begin
                // Accumulate wraps modulo 2^(2*WIDTH); carry out is dropped.
                if (maddu_q) begin
                    {hi_d, lo_d} = {hi_q, lo_q} + product_q;
                end else begin
                    {hi_d, lo_d} = product_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
            maddu_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
            maddu_q   <= maddu_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign state_o = state_q;

endmodule
